hss_sample_reader: RTL and testbench

// - Reader end of the filter output stream: captures the free-running signed sample bus

---
 rtl/hss_sample_reader_pkg.sv | 15 +
 rtl/hss_sync_fifo.sv | 59 +++++
 rtl/hss_sample_reader.sv | 75 +++++++
 tb/tb_hss_sample_reader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hss_sample_reader_pkg.sv
// Shared sizing constants for the HSS filter / sample reader / register-interface chain.
package hss_sample_reader_pkg;

    localparam int HSS_SAMPLE_W  = 32;
    localparam int HSS_RDR_DEPTH = 16;
    localparam int HSS_DECIM_W   = 16;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_t;

endpackage

// File: rtl/hss_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read; rd_data is forced to 0 while empty.
module hss_sync_fifo
    import hss_sample_reader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              do_push;
    logic              do_pop;
    fifo_op_t          op;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a push is only legal if the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign op      = fifo_op_t'({do_push, do_pop});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case (op)
                FIFO_PUSH: count_reg <= count_reg + (AW+1)'(1);
                FIFO_POP:  count_reg <= count_reg - (AW+1)'(1);
                default:   count_reg <= count_reg;
            endcase
        end
    end

    // Storage is intentionally not reset; stale contents are masked by the empty check.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/hss_sample_reader.sv
// Captures the free-running filter output at a programmable decimation rate into a FIFO
// that the CPU side drains through a valid/ready handshake.
module hss_sample_reader
    import hss_sample_reader_pkg::*;
#(
    parameter int DATA_W  = HSS_SAMPLE_W,
    parameter int DEPTH   = HSS_RDR_DEPTH,
    parameter int DECIM_W = HSS_DECIM_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     en,
    input  logic [DECIM_W-1:0]       decim,
    input  logic [DATA_W-1:0]        sample_in,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);
    logic [DECIM_W-1:0] dcnt_reg;
    logic               ovf_reg;
    logic               capture;
    logic               pop;
    logic               push;
    logic               full;
    logic               empty;

    assign capture  = en && (dcnt_reg == '0);
    assign pop      = rd_valid && rd_ready;
    assign push     = capture && (!full || pop);
    assign rd_valid = !empty;

    // A new decim value is picked up only at the next reload, never mid-countdown.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dcnt_reg <= '0;
        end else if (!en) begin
            dcnt_reg <= '0;
        end else if (dcnt_reg == '0) begin
            dcnt_reg <= decim;
        end else begin
            dcnt_reg <= dcnt_reg - DECIM_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_reg <= 1'b0;
        end else if (capture && !push) begin
            ovf_reg <= 1'b1;
        end else if (clr_ovf) begin
            ovf_reg <= 1'b0;
        end
    end

    assign overflow = ovf_reg;

    hss_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (push),
        .wr_data (sample_in),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

endmodule

// File: tb/tb_hss_sample_reader.sv
// Self-checking bench for hss_sample_reader: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_hss_sample_reader;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int DCW   = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          en = 1'b0;
    logic [DCW-1:0] decim = '0;
    logic [DW-1:0] sample_in = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic [4:0]    count;
    logic          overflow;
    logic          clr_ovf = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] m_q[$];
    int            m_wait = 0;
    bit            m_ovf = 0;

    always #5 CLK = ~CLK;

    hss_sample_reader dut (
        .CLK       (CLK),
        .RST       (RST),
        .en        (en),
        .decim     (decim),
        .sample_in (sample_in),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    function automatic logic [DW-1:0] exp_data();
        return (m_q.size() != 0) ? m_q[0] : '0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_wait = 0;
        m_ovf  = 0;
    endtask

    // Advance the reference model by one clock using the current inputs, then clock the DUT.
    task automatic tick();
        bit cap, pp, ps;
        cap = en && (m_wait == 0);
        pp  = (m_q.size() != 0) && rd_ready;
        ps  = cap && ((m_q.size() < DEPTH) || pp);
        if (cap && !ps) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
        if (pp) void'(m_q.pop_front());
        if (ps) m_q.push_back(sample_in);
        if (!en) m_wait = 0;
        else if (m_wait == 0) m_wait = int'(decim);
        else m_wait = m_wait - 1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got=%0b want=0", rd_valid); end
        n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", count); end
        n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
        RST = 1'b0;
        model_reset();
        en = 1'b1; decim = '0; rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_in = DW'(i + 10);
            tick();
        end
        en = 1'b0;
        n_cmp++; if (count !== 5'd5) begin n_bad++; $display("FAIL prereset_count got=%0d want=5", count); end
        #2 RST = 1'b1;
        #1;
        model_reset();
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_rd_valid got=%0b want=0", rd_valid); end
        n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL midreset_count got=%0d want=0", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL midreset_overflow got=%0b want=0", overflow); end
        n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL midreset_rd_data got=%h want=0", rd_data); end
        #3 RST = 1'b0;
        tick();
        $display("test_reset done: count=%0d rd_valid=%0b", count, rd_valid);
    endtask

    task automatic test_basic();
        logic [DW-1:0] vals [4];
        vals[0] = 32'sd1; vals[1] = -32'sd2; vals[2] = 32'sd3; vals[3] = -32'sd4;
        en = 1'b1; decim = '0; rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_in = vals[i];
            tick();
        end
        en = 1'b0;
        n_cmp++; if (count !== 5'd4) begin n_bad++; $display("FAIL basic_count got=%0d want=4", count); end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== vals[i]) begin
                n_bad++; $display("FAIL basic_read%0d got=%h valid=%0b want=%h", i, rd_data, rd_valid, vals[i]);
            end
            tick();
        end
        rd_ready = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drained got=%0b want=0", rd_valid); end
        $display("test_basic done: count=%0d", count);
    endtask

    task automatic test_decim();
        en = 1'b1; decim = DCW'(3); rd_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sample_in = DW'(i);
            tick();
        end
        en = 1'b0;
        n_cmp++; if (count !== 5'd3) begin n_bad++; $display("FAIL decim_count got=%0d want=3", count); end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rd_data !== DW'(4 * i)) begin
                n_bad++; $display("FAIL decim_read%0d got=%0d want=%0d", i, rd_data, 4 * i);
            end
            tick();
        end
        rd_ready = 1'b0; decim = '0;
        $display("test_decim done: count=%0d", count);
    endtask

    task automatic test_overflow();
        en = 1'b1; decim = '0; rd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sample_in = DW'(100 + i);
            tick();
        end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_at_full got=%0b want=0", overflow); end
        sample_in = DW'(999);
        tick();
        en = 1'b0;
        n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL ovf_count got=%0d want=16", count); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%0b want=1", overflow); end
        n_cmp++; if (rd_data !== DW'(100)) begin n_bad++; $display("FAIL ovf_head got=%0d want=100", rd_data); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got=%0b want=0", overflow); end
        $display("test_overflow done: count=%0d", count);
    endtask

    task automatic test_full_pop();
        en = 1'b1; rd_ready = 1'b1; sample_in = DW'(555);
        tick();
        en = 1'b0; rd_ready = 1'b0;
        n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL fullpop_count got=%0d want=16", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fullpop_ovf got=%0b want=0", overflow); end
        n_cmp++; if (rd_data !== DW'(101)) begin n_bad++; $display("FAIL fullpop_head got=%0d want=101", rd_data); end
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (rd_data !== exp_data()) begin
                n_bad++; $display("FAIL fullpop_drain%0d got=%0d want=%0d", i, rd_data, exp_data());
            end
            if (i == DEPTH - 1) begin
                n_cmp++; if (rd_data !== DW'(555)) begin n_bad++; $display("FAIL fullpop_tail got=%0d want=555", rd_data); end
            end
            tick();
        end
        rd_ready = 1'b0;
        $display("test_full_pop done: count=%0d", count);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] sent[$];
        int reads = 0;
        en = 1'b1; decim = '0; rd_ready = 1'b1;
        for (int i = 0; i < 42; i++) begin
            if (i == 40) en = 1'b0;
            sample_in = $urandom;
            if (en) sent.push_back(sample_in);
            if (rd_valid) begin
                n_cmp++; if (reads >= sent.size() || rd_data !== sent[reads]) begin
                    n_bad++; $display("FAIL b2b_read%0d got=%h want=%h", reads, rd_data, exp_data());
                end
                reads++;
            end
            n_cmp++; if (count > 5'd1) begin n_bad++; $display("FAIL b2b_count got=%0d want<=1", count); end
            tick();
        end
        rd_ready = 1'b0;
        n_cmp++; if (reads != 40) begin n_bad++; $display("FAIL b2b_reads got=%0d want=40", reads); end
        $display("test_back_to_back done: reads=%0d", reads);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) decim = DCW'($urandom_range(0, 3));
            rd_ready = ($urandom_range(0, 9) < 4);
            clr_ovf  = ($urandom_range(0, 7) == 0);
            sample_in = $urandom;
            tick();
            n_cmp++; if (count !== 5'(m_q.size()) || rd_valid !== (m_q.size() != 0)) begin
                n_bad++; $display("FAIL rand_occ cyc=%0d got=%0d/%0b want=%0d", i, count, rd_valid, m_q.size());
            end
            n_cmp++; if (rd_data !== exp_data()) begin
                n_bad++; $display("FAIL rand_data cyc=%0d got=%h want=%h", i, rd_data, exp_data());
            end
            n_cmp++; if (overflow !== m_ovf) begin
                n_bad++; $display("FAIL rand_ovf cyc=%0d got=%0b want=%0b", i, overflow, m_ovf);
            end
        end
        en = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
        $display("test_random done: count=%0d overflow=%0b", count, overflow);
    endtask

    initial begin
        #12;
        test_reset();
        test_basic();
        test_decim();
        test_overflow();
        test_full_pop();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
